// File: rtl/spi_mnrch.sv
// SPI monarch: one 16-bit full-duplex transaction per accepted wrt.
// SCLK is clk/32 and idles high; MISO is sampled on SCLK rise and shifted in on SCLK fall.
module spi_mnrch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {IDLE, FRONT_PORCH, SHIFTING} state_t;

  localparam logic [4:0] DIV_IDLE = 5'b10111;

  state_t      state, nxt_state;
  logic [4:0]  sclk_div;
  logic [15:0] shft_reg;
  logic [3:0]  bit_cnt;
  logic        miso_smpl;
  logic        smpl, shft;
  logic        load, do_shft, finish;

  assign smpl = (sclk_div == 5'b01111);
  assign shft = (sclk_div == 5'b11111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // The porch state swallows the first SCLK fall so bit 15 is held for a full low phase.
  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    do_shft   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (wrt) begin
          load      = 1'b1;
          nxt_state = FRONT_PORCH;
        end
      end
      FRONT_PORCH: begin
        if (shft) nxt_state = SHIFTING;
      end
      SHIFTING: begin
        if (shft) begin
          do_shft = 1'b1;
          if (bit_cnt == 4'd15) begin
            finish    = 1'b1;
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Reloading on finish keeps SCLK high, so there is no 17th falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    sclk_div <= DIV_IDLE;
    else if (load || finish || (state == IDLE))    sclk_div <= DIV_IDLE;
    else                                           sclk_div <= sclk_div + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     miso_smpl <= 1'b0;
    else if (smpl)  miso_smpl <= MISO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft_reg <= '0;
      bit_cnt  <= '0;
    end else if (load) begin
      shft_reg <= wt_data;
      bit_cnt  <= '0;
    end else if (do_shft) begin
      shft_reg <= {shft_reg[14:0], miso_smpl};
      bit_cnt  <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n <= 1'b1;
      done <= 1'b0;
    end else if (load) begin
      SS_n <= 1'b0;
      done <= 1'b0;
    end else if (finish) begin
      SS_n <= 1'b1;
      done <= 1'b1;
    end
  end

  assign SCLK    = sclk_div[4];
  assign MOSI    = shft_reg[15];
  assign rd_data = shft_reg;

endmodule

// File: tb/tb_spi_mnrch.sv
// Directed bench for spi_mnrch: serf model, loopback, tied MISO, timing, re-pulse and abort.
module tb_spi_mnrch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt;
  logic [15:0] wt_data;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n, SCLK, MOSI, MISO;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // 0: tied 0, 1: tied 1, 2: loopback, 3: serf model
  int          miso_mode;
  logic [15:0] serf_pat;
  int          serf_idx;
  logic        serf_bit;
  int          fall_cnt;
  logic [15:0] mosi_cap;
  int          first_fall, first_rise, second_fall;
  int          repulse_at;
  int          lat;

  spi_mnrch dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .wt_data (wt_data),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always #5 clk = ~clk;

  always_comb begin
    MISO = 1'b0;
    case (miso_mode)
      1:       MISO = 1'b1;
      2:       MISO = MOSI;
      3:       MISO = serf_bit;
      default: MISO = 1'b0;
    endcase
  end

  // Serf drives the next bit on every SCLK fall; the porch fall presents bit 15.
  always @(negedge SS_n) begin
    serf_idx = 16;
    serf_bit = 1'b0;
  end

  always @(negedge SCLK) begin
    if (!SS_n) begin
      fall_cnt = fall_cnt + 1;
      if (serf_idx > 0) begin
        serf_bit = serf_pat[serf_idx-1];
        serf_idx = serf_idx - 1;
      end
    end
  end

  always @(posedge SCLK) begin
    if (!SS_n) mosi_cap = {mosi_cap[14:0], MOSI};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns with the accept edge just passed.
  task automatic start_xfer(input logic [15:0] d);
    @(negedge clk);
    wt_data  = d;
    wrt      = 1'b1;
    fall_cnt = 0;
    mosi_cap = '0;
    @(posedge clk);
    #1;
    wrt = 1'b0;
  endtask

  // Counts edges from the accept edge until done; lat=0 means the budget expired.
  task automatic wait_done(output int l);
    l           = 0;
    first_fall  = 0;
    first_rise  = 0;
    second_fall = 0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk);
      #1;
      if (first_fall == 0 && SCLK == 1'b0) first_fall = n;
      else if (first_fall != 0 && first_rise == 0 && SCLK == 1'b1) first_rise = n;
      else if (first_rise != 0 && second_fall == 0 && SCLK == 1'b0) second_fall = n;
      if (repulse_at != 0 && n == repulse_at) begin
        wrt     = 1'b1;
        wt_data = 16'hFFFF;
      end
      if (repulse_at != 0 && n == repulse_at + 1) wrt = 1'b0;
      if (done) begin
        l = n;
        break;
      end
    end
    if (l == 0) $display("FAIL wait_done: no done within 600 clk");
  endtask

  initial begin
    rst_n      = 1'b0;
    wrt        = 1'b0;
    wt_data    = '0;
    miso_mode  = 0;
    serf_pat   = '0;
    serf_idx   = 0;
    serf_bit   = 1'b0;
    fall_cnt   = 0;
    mosi_cap   = '0;
    repulse_at = 0;
    #12;
    chk("rst_ss_n",    {31'd0, SS_n}, 32'd1);
    chk("rst_sclk",    {31'd0, SCLK}, 32'd1);
    chk("rst_done",    {31'd0, done}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'h0000);
    chk("rst_mosi",    {31'd0, MOSI}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Serf read of WHO_AM_I; timing: div 23..31 porch = first fall on edge 9,
    // rise 16 later, fall 16 after that, 16th shift on edge 9+32*16 = 521.
    miso_mode = 3;
    serf_pat  = 16'h006A;
    start_xfer(16'h8F00);
    chk("ss_n_low_after_accept", {31'd0, SS_n}, 32'd0);
    chk("done_clr_on_accept",    {31'd0, done}, 32'd0);
    wait_done(lat);
    chk("done_latency",   lat,         32'd521);
    chk("first_fall",     first_fall,  32'd9);
    chk("first_rise",     first_rise,  32'd25);
    chk("second_fall",    second_fall, 32'd41);
    chk("whoami",         {24'd0, rd_data[7:0]}, 32'h6A);
    chk("serf_word",      {16'd0, rd_data}, 32'h006A);
    chk("serf_ss_n_end",  {31'd0, SS_n}, 32'd1);
    chk("serf_sclk_end",  {31'd0, SCLK}, 32'd1);
    chk("serf_mosi_bits", {16'd0, mosi_cap}, 32'h8F00);

    // Loopback returns the transmitted word after 16 rotations.
    miso_mode = 2;
    start_xfer(16'hA5C3);
    wait_done(lat);
    chk("loop_rd_data",   {16'd0, rd_data}, 32'hA5C3);
    chk("loop_falls",     fall_cnt, 32'd16);
    chk("loop_mosi_bits", {16'd0, mosi_cap}, 32'hA5C3);

    miso_mode = 1;
    start_xfer(16'h1234);
    wait_done(lat);
    chk("tie1_rd_data",   {16'd0, rd_data}, 32'hFFFF);
    chk("tie1_mosi_bits", {16'd0, mosi_cap}, 32'h1234);

    miso_mode = 0;
    start_xfer(16'h1234);
    wait_done(lat);
    chk("tie0_rd_data",   {16'd0, rd_data}, 32'h0000);
    chk("tie0_mosi_bits", {16'd0, mosi_cap}, 32'h1234);
    repeat (10) @(posedge clk);
    #1;
    chk("done_held_idle", {31'd0, done}, 32'd1);

    // A wrt mid-transfer must not disturb the running word.
    miso_mode  = 2;
    repulse_at = 100;
    start_xfer(16'h5A3C);
    wait_done(lat);
    repulse_at = 0;
    chk("repulse_latency", lat, 32'd521);
    chk("repulse_rd_data", {16'd0, rd_data}, 32'h5A3C);
    chk("repulse_falls",   fall_cnt, 32'd16);

    // wrt held high: done is high for exactly one clk between transactions.
    @(negedge clk);
    wt_data  = 16'hC3A5;
    wrt      = 1'b1;
    fall_cnt = 0;
    @(posedge clk);
    #1;
    wait_done(lat);
    chk("b2b_first_latency", lat, 32'd521);
    chk("b2b_first_rd_data", {16'd0, rd_data}, 32'hC3A5);
    @(posedge clk);
    #1;
    chk("b2b_done_one_clk", {31'd0, done}, 32'd0);
    chk("b2b_ss_n_restart", {31'd0, SS_n}, 32'd0);
    wrt = 1'b0;
    wait_done(lat);
    chk("b2b_second_latency", lat, 32'd521);
    chk("b2b_second_rd_data", {16'd0, rd_data}, 32'hC3A5);

    // Asynchronous abort around bit 7 (edge 9+32*7), away from any clk edge.
    miso_mode = 1;
    start_xfer(16'h0F0F);
    repeat (233) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_ss_n",    {31'd0, SS_n}, 32'd1);
    chk("abort_sclk",    {31'd0, SCLK}, 32'd1);
    chk("abort_done",    {31'd0, done}, 32'd0);
    chk("abort_rd_data", {16'd0, rd_data}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    start_xfer(16'h1234);
    wait_done(lat);
    chk("post_abort_latency", lat, 32'd521);
    chk("post_abort_rd_data", {16'd0, rd_data}, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
